// File: rtl/fc8_tile_line_engine_pkg.sv
// Shared fc8 defines: attribute bit positions, fetch FSM encodings and the
// default tile-pattern base address.
package fc8_tile_line_engine_pkg;
  localparam int FLIPX_BIT = 7;
  localparam int FLIPY_BIT = 6;
  localparam int PAL_MSB   = 3;
  localparam int PAL_LSB   = 0;

  localparam logic [15:0] VRAM_TILE_PATTERN_BASE_ADDR = 16'h4000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_ID   = 3'd1,
    FETCH_ATTR = 3'd2,
    FETCH_PAT  = 3'd3,
    NEXT_TILE  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] attr;
  } tile_ent_t;
endpackage

// File: rtl/fc8_tile_line_engine_if.sv
// Memory-side bus of the tile line engine: tilemap definition RAM and VRAM
// read ports, both with one cycle of read latency.
interface fc8_tile_line_engine_if #(parameter int VRAM_AW = 16);
  logic [10:0]        def_addr;
  logic [7:0]         def_data;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_data;

  modport master (output def_addr, vram_addr, input def_data, vram_data);
  modport slave  (input def_addr, vram_addr, output def_data, vram_data);
endinterface

// File: rtl/fc8_tile_line_engine_line_buffer.sv
// Double line buffer: front is read for display, back is written by the
// fetch engine; swap flips the roles.
module fc8_line_buffer #(
  parameter int DEPTH = 264,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic       front;
  logic [7:0] buf0 [DEPTH];
  logic [7:0] buf1 [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front) buf0[wr_addr] <= wr_data;
      else       buf1[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front   <= 1'b0;
      rd_data <= '0;
    end else begin
      if (swap) front <= ~front;
      rd_data <= !rd_en ? 8'h00 : (front ? buf1[rd_addr] : buf0[rd_addr]);
    end
  end
endmodule

// File: rtl/fc8_tile_line_engine.sv
// Tilemap line engine: prefetches one screen line of tile pixels into a back
// buffer while the front buffer feeds display. FC8_TILE_SCROLL_EN enables scroll.
module fc8_tile_line_engine
  import fc8_tile_line_engine_pkg::*;
#(
  parameter int          TILE_PX  = 8,
  parameter int          MAP_COLS = 32,
  parameter int          MAP_ROWS = 32,
  parameter int          SCREEN_W = 256,
  parameter logic [15:0] PAT_BASE = VRAM_TILE_PATTERN_BASE_ADDR,
  parameter int          VRAM_AW  = 16
) (
  input  logic                  master_clk,
  input  logic                  master_rst_n,
  input  logic                  enable,
  input  logic                  line_start,
  input  logic [8:0]            next_y,
  input  logic [8:0]            px_x,
  input  logic [8:0]            scroll_x,
  input  logic [8:0]            scroll_y,
  fc8_tile_line_engine_if.master mem,
  output logic [7:0]            pix_index,
  output logic                  fetch_busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);
  localparam int TB = $clog2(TILE_PX);
`ifdef FC8_TILE_SCROLL_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NT    = SCREEN_W / TILE_PX + EXTRA;
  localparam int NW    = $clog2(NT + 1);
  localparam int LB_AW = $clog2(SCREEN_W + TILE_PX);
  localparam logic [NW-1:0] N_LAST   = NW'(NT - 1);
  localparam logic [TB:0]   CNT_LAST = (TB+1)'(TILE_PX);

  logic [8:0] sx_in, sy_in;
`ifdef FC8_TILE_SCROLL_EN
  assign sx_in = scroll_x;
  assign sy_in = scroll_y;
`else
  logic unused_scroll;
  assign unused_scroll = ^{scroll_x, scroll_y};
  assign sx_in = '0;
  assign sy_in = '0;
`endif

  fetch_state_t             state;
  tile_ent_t                tile_q;
  logic [8:0]               y_q, sx_q, sy_q, ysum;
  logic [TB-1:0]            fine_q, row_eff, wr_col;
  logic [TB:0]              cnt;
  logic [NW-1:0]            n_q;
  logic [1:0]               vld_pipe;
  logic [1:0][TB-1:0]       col_pipe;
  logic                     issue, flip_y, rd_en, unused_bits;
  logic [VRAM_AW-1:0]       vram_next;
  logic [LB_AW-1:0]         wr_addr, rd_addr;
  logic [7:0]               wr_data;

  function automatic logic [10:0] map_addr(input logic [8:0] y, sx, sy,
                                           input logic [NW-1:0] n);
    logic [8:0] ys;
    ys = y + sy;
    return 11'(((int'(ys >> TB) % MAP_ROWS) * MAP_COLS
                + (int'(sx >> TB) + int'(n)) % MAP_COLS) * 2);
  endfunction

  // Attr arrives on def_data during the first pattern cycle, before it is latched.
  assign ysum    = y_q + sy_q;
  assign flip_y  = (cnt == '0) ? mem.def_data[FLIPY_BIT] : tile_q.attr[FLIPY_BIT];
  assign row_eff = flip_y ? ~ysum[TB-1:0] : ysum[TB-1:0];
  assign issue   = (state == FETCH_PAT) && (cnt != CNT_LAST);
  assign vram_next = VRAM_AW'(int'(PAT_BASE) + int'(tile_q.id) * TILE_PX * TILE_PX
                              + int'(row_eff) * TILE_PX + int'(cnt));

  assign wr_col  = tile_q.attr[FLIPX_BIT] ? ~col_pipe[1] : col_pipe[1];
  assign wr_addr = LB_AW'(int'(n_q) * TILE_PX + int'(wr_col));
  assign wr_data = {tile_q.attr[PAL_MSB:PAL_LSB], mem.vram_data[3:0]};
  assign rd_en   = enable && (int'(px_x) < SCREEN_W);
  assign rd_addr = LB_AW'(int'(px_x) + int'(fine_q));
  assign fetch_busy  = (state != IDLE);
  assign unused_bits = ^{ysum, mem.vram_data[7:4], tile_q.attr[5:4]};

  always_ff @(posedge master_clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      state        <= IDLE;
      mem.def_addr <= '0;
      mem.vram_addr <= '0;
      overrun      <= 1'b0;
      tile_q       <= '0;
      y_q          <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      fine_q       <= '0;
      cnt          <= '0;
      n_q          <= '0;
      vld_pipe     <= '0;
      col_pipe     <= '0;
    end else begin
      overrun  <= (enable && line_start && state != IDLE) || (overrun && !overrun_clr);
      vld_pipe <= {vld_pipe[0], issue};
      col_pipe <= {col_pipe[0], cnt[TB-1:0]};
      if (!enable) begin
        state    <= IDLE;
        vld_pipe <= '0;
      end else if (line_start) begin
        // Back buffer becomes front, so its fetch-time scroll now drives display.
        fine_q       <= sx_q[TB-1:0];
        y_q          <= next_y;
        sx_q         <= sx_in;
        sy_q         <= sy_in;
        n_q          <= '0;
        vld_pipe     <= '0;
        mem.def_addr <= map_addr(next_y, sx_in, sy_in, '0);
        state        <= FETCH_ID;
      end else begin
        case (state)
          FETCH_ID: begin
            mem.def_addr <= mem.def_addr + 11'd1;
            state        <= FETCH_ATTR;
          end
          FETCH_ATTR: begin
            tile_q.id <= mem.def_data;
            cnt       <= '0;
            state     <= FETCH_PAT;
          end
          FETCH_PAT: begin
            if (cnt == '0) tile_q.attr <= mem.def_data;
            if (issue) mem.vram_addr <= vram_next;
            if (cnt == CNT_LAST) state <= NEXT_TILE;
            else                 cnt   <= cnt + 1'b1;
          end
          NEXT_TILE: begin
            if (n_q == N_LAST) begin
              state <= IDLE;
            end else begin
              n_q          <= n_q + 1'b1;
              mem.def_addr <= map_addr(y_q, sx_q, sy_q, n_q + 1'b1);
              state        <= FETCH_ID;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  fc8_line_buffer #(.DEPTH(SCREEN_W + TILE_PX), .AW(LB_AW)) lbuf (
    .clk     (master_clk),
    .rst_n   (master_rst_n),
    .swap    (enable && line_start),
    .wr_en   (vld_pipe[1]),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (pix_index)
  );
endmodule

// File: tb/tb_fc8_tile_line_engine.sv
// Directed bench for fc8_tile_line_engine: table of line/pixel vectors plus
// hand sequences for overrun, enable gating and mid-fetch reset.
module tb_fc8_tile_line_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable, line_start, overrun_clr;
  logic [8:0] next_y, px_x, scroll_x, scroll_y;
  logic [7:0] pix_index;
  logic       fetch_busy, overrun;

  fc8_tile_line_engine_if #(.VRAM_AW(16)) bus ();

  fc8_tile_line_engine dut (
    .master_clk   (clk),
    .master_rst_n (rst_n),
    .enable       (enable),
    .line_start   (line_start),
    .next_y       (next_y),
    .px_x         (px_x),
    .scroll_x     (scroll_x),
    .scroll_y     (scroll_y),
    .mem          (bus),
    .pix_index    (pix_index),
    .fetch_busy   (fetch_busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  logic [7:0] def_mem [2048];
  logic [7:0] vram [65536];

  always @(posedge clk) begin
    bus.def_data  <= def_mem[bus.def_addr];
    bus.vram_data <= vram[bus.vram_addr];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    y;
    int    sx;
    int    sy;
    int    x;
    int    exp;
    string name;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic ls_pulse(input int y);
    @(negedge clk);
    next_y = 9'(y);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (fetch_busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (fetch_busy) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout got busy want idle");
    end
  endtask

  task automatic read_px(input int x, output int v);
    px_x = 9'(x);
    @(negedge clk);
    v = int'(pix_index);
  endtask

  initial begin
    vec_t vecs[$];
    int   v;
    enable = 1'b1; line_start = 1'b0; overrun_clr = 1'b0;
    next_y = '0; px_x = '0; scroll_x = '0; scroll_y = '0;

    for (int i = 0; i < 2048; i++)  def_mem[i] = 8'h00;
    for (int i = 0; i < 65536; i++) vram[i] = 8'h00;
    def_mem[0] = 8'h01; def_mem[1] = 8'h00;
    def_mem[2] = 8'h02; def_mem[3] = 8'h81;
    def_mem[4] = 8'h03; def_mem[5] = 8'h40;
    def_mem[6] = 8'h04; def_mem[7] = 8'h0A;
    def_mem[62] = 8'h06; def_mem[63] = 8'h0C;
    for (int i = 0; i < 64; i++) vram[16'h4040 + i] = 8'h05;
    for (int c = 0; c < 8; c++) begin
      vram[16'h4080 + c]      = 8'(c);
      vram[16'h40C0 + c]      = 8'h01;
      vram[16'h40C0 + 48 + c] = 8'h04;
      vram[16'h40C0 + 56 + c] = 8'(8 + c);
      vram[16'h4100 + c]      = 8'h03;
      vram[16'h4108 + c]      = 8'h06;
      vram[16'h4180 + c]      = 8'h07;
    end

    #12;
    chk("rst_pix", int'(pix_index), 0);
    chk("rst_def_addr", int'(bus.def_addr), 0);
    chk("rst_vram_addr", int'(bus.vram_addr), 0);
    chk("rst_busy", int'(fetch_busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{0, 0, 0, 0,   'h05, "t00_px0"});
    vecs.push_back('{0, 0, 0, 7,   'h05, "t00_px7"});
    vecs.push_back('{0, 0, 0, 8,   'h17, "flipx_px8"});
    vecs.push_back('{0, 0, 0, 15,  'h10, "flipx_px15"});
    vecs.push_back('{0, 0, 0, 16,  'h08, "flipy_px16"});
    vecs.push_back('{0, 0, 0, 23,  'h0F, "flipy_px23"});
    vecs.push_back('{1, 0, 0, 16,  'h04, "flipy_row1"});
    vecs.push_back('{0, 0, 0, 24,  'hA3, "pal_px24"});
    vecs.push_back('{1, 0, 0, 24,  'hA6, "row1_px24"});
    vecs.push_back('{0, 0, 0, 255, 'hC7, "last_tile"});
    vecs.push_back('{0, 0, 0, 256, 'h00, "x_oob256"});
    vecs.push_back('{0, 0, 0, 511, 'h00, "x_oob511"});
    vecs.push_back('{256, 0, 0, 8, 'h17, "ywrap256"});
`ifdef FC8_TILE_SCROLL_EN
    vecs.push_back('{0, 8, 0, 8,   'h08, "sx8_px8"});
    vecs.push_back('{0, 4, 0, 4,   'h17, "sx4_px4"});
    vecs.push_back('{0, 252, 0, 0, 'hC7, "sx252_px0"});
    vecs.push_back('{0, 252, 0, 4, 'h05, "sx252_wrap"});
    vecs.push_back('{0, 0, 1, 24,  'hA6, "sy1_px24"});
`else
    vecs.push_back('{0, 8, 0, 8,   'h17, "sx_ignored"});
    vecs.push_back('{0, 0, 1, 24,  'hA3, "sy_ignored"});
`endif

    foreach (vecs[i]) begin
      scroll_x = 9'(vecs[i].sx);
      scroll_y = 9'(vecs[i].sy);
      ls_pulse(vecs[i].y);
      if (i == 0) chk("busy_after_ls", int'(fetch_busy), 1);
      wait_idle();
      ls_pulse(vecs[i].y);
      read_px(vecs[i].x, v);
      chk(vecs[i].name, v, vecs[i].exp);
      wait_idle();
    end
    scroll_x = '0;
    scroll_y = '0;

    // Overrun: second line_start ~50 cycles into a fetch.
    ls_pulse(0);
    repeat (48) @(negedge clk);
    ls_pulse(0);
    chk("overrun_set", int'(overrun), 1);
    chk("busy_restart", int'(fetch_busy), 1);
    wait_idle();
    chk("overrun_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_clr", int'(overrun), 0);
    ls_pulse(0);
    repeat (10) @(negedge clk);
    overrun_clr = 1'b1;
    ls_pulse(0);
    overrun_clr = 1'b0;
    chk("clr_vs_set", int'(overrun), 1);
    wait_idle();
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    ls_pulse(0);
    read_px(8, v);
    chk("restart_data", v, 'h17);
    wait_idle();

    // Enable gating: last fetch was line 0, unscrolled.
`ifdef FC8_TILE_SCROLL_EN
    chk("last_def_addr", int'(bus.def_addr), 1);
    chk("last_vram_addr", int'(bus.vram_addr), 'h4047);
`else
    chk("last_def_addr", int'(bus.def_addr), 63);
    chk("last_vram_addr", int'(bus.vram_addr), 'h4187);
`endif
    enable = 1'b0;
    ls_pulse(100);
    @(negedge clk);
`ifdef FC8_TILE_SCROLL_EN
    chk("dis_def_addr", int'(bus.def_addr), 1);
`else
    chk("dis_def_addr", int'(bus.def_addr), 63);
`endif
    chk("dis_busy", int'(fetch_busy), 0);
    chk("dis_pix", int'(pix_index), 0);
    enable = 1'b1;
    ls_pulse(0);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_abort", int'(fetch_busy), 0);
    enable = 1'b1;

    // Reset mid FETCH_PAT with a valid front line on display.
    ls_pulse(0);
    wait_idle();
    ls_pulse(0);
    read_px(0, v);
    chk("pre_rst_pix", v, 'h05);
    wait_idle();
    ls_pulse(0);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", int'(fetch_busy), 1);
    chk("pre_rst_pix2", int'(pix_index), 'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(fetch_busy), 0);
    chk("midrst_pix", int'(pix_index), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ls_pulse(0);
    wait_idle();
    ls_pulse(0);
    read_px(8, v);
    chk("post_rst_data", v, 'h17);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
